// File: rtl/insn_class_pkg.sv
//------------------------------------------------------------------------------
// Module  : insn_class_pkg
// Brief   : Opcodes, one-hot class indices and the shared opcode decode
//           function. FP_DECODE_EN enables F-extension opcodes.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package insn_class_pkg;

    localparam int CLS_W     = 10;
    localparam int CLS_J     = 0;
    localparam int CLS_JR    = 1;
    localparam int CLS_LUI   = 2;
    localparam int CLS_AUIPC = 3;
    localparam int CLS_BR    = 4;
    localparam int CLS_OP    = 5;
    localparam int CLS_ST    = 6;
    localparam int CLS_OPI   = 7;
    localparam int CLS_LD    = 8;
    localparam int CLS_SYS   = 9;

    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_FMADD     = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB     = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [CLS_W-1:0] code;
        logic             illegal;
`ifdef FP_DECODE_EN
        logic             fp;
`endif
    } cls_dec_t;

    // Opcodes with insn[1:0] != 2'b11 never match an entry and fall out illegal.
    function automatic cls_dec_t decode_opcode(input logic [6:0] opc, input logic rv64w);
        cls_dec_t d;
        d = '0;
        case (opc)
            OPC_JAL:       d.code[CLS_J]     = 1'b1;
            OPC_JALR:      d.code[CLS_JR]    = 1'b1;
            OPC_LUI:       d.code[CLS_LUI]   = 1'b1;
            OPC_AUIPC:     d.code[CLS_AUIPC] = 1'b1;
            OPC_BRANCH:    d.code[CLS_BR]    = 1'b1;
            OPC_OP:        d.code[CLS_OP]    = 1'b1;
            OPC_OP_32:     d.code[CLS_OP]    = rv64w;
            OPC_STORE:     d.code[CLS_ST]    = 1'b1;
            OPC_OP_IMM:    d.code[CLS_OPI]   = 1'b1;
            OPC_OP_IMM_32: d.code[CLS_OPI]   = rv64w;
            OPC_LOAD:      d.code[CLS_LD]    = 1'b1;
            OPC_SYSTEM:    d.code[CLS_SYS]   = 1'b1;
`ifdef FP_DECODE_EN
            OPC_LOAD_FP:   begin d.code[CLS_LD] = 1'b1; d.fp = 1'b1; end
            OPC_STORE_FP:  begin d.code[CLS_ST] = 1'b1; d.fp = 1'b1; end
            OPC_OP_FP,
            OPC_FMADD,
            OPC_FMSUB,
            OPC_FNMSUB,
            OPC_FNMADD:    begin d.code[CLS_OP] = 1'b1; d.fp = 1'b1; end
`endif
            default:       d.code = '0;
        endcase
        d.illegal = (d.code == '0);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/insn_class_decode_comb.sv
//------------------------------------------------------------------------------
// Module  : insn_class_comb
// Brief   : Combinational opcode to one-hot class / illegal (/ fp with
//           FP_DECODE_EN).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module insn_class_comb
    import insn_class_pkg::*;
#(
    parameter int RV64_W = 1
) (
    input  logic [6:0]       i_opcode,
    output logic [CLS_W-1:0] o_code,
    output logic             o_illegal
`ifdef FP_DECODE_EN
    ,
    output logic             o_fp
`endif
);

    cls_dec_t w_dec;

    assign w_dec     = decode_opcode(i_opcode, (RV64_W != 0));
    assign o_code    = w_dec.code;
    assign o_illegal = w_dec.illegal;
`ifdef FP_DECODE_EN
    assign o_fp      = w_dec.fp;
`endif

endmodule

`default_nettype wire

// File: rtl/insn_class_decode.sv
//------------------------------------------------------------------------------
// Module  : insn_class_decode
// Brief   : Instruction class decode registered behind a 2-entry skid buffer
//           with valid/ready, flush and illegal detection. FP_DECODE_EN adds fp.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module insn_class_decode
    import insn_class_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int RV64_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      insn_in,
    input  logic [XLEN-1:0]  pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] code,
    output logic [31:0]      insn_out,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal
`ifdef FP_DECODE_EN
    ,
    output logic             fp
`endif
);

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_head;
    logic             w_load_skid;
    logic             w_skid_to_head;

    logic [CLS_W-1:0] w_code;
    logic             w_illegal;

    logic [CLS_W-1:0] r_head_code;
    logic             r_head_ill;
    logic [31:0]      r_head_insn;
    logic [XLEN-1:0]  r_head_pc;
    logic [CLS_W-1:0] r_skid_code;
    logic             r_skid_ill;
    logic [31:0]      r_skid_insn;
    logic [XLEN-1:0]  r_skid_pc;
`ifdef FP_DECODE_EN
    logic             w_fp;
    logic             r_head_fp;
    logic             r_skid_fp;
`endif

    insn_class_comb #(
        .RV64_W    (RV64_W)
    ) u_comb (
        .i_opcode  (insn_in[6:0]),
        .o_code    (w_code),
        .o_illegal (w_illegal)
`ifdef FP_DECODE_EN
        ,
        .o_fp      (w_fp)
`endif
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != BUF_EMPTY);
    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = BUF_ONE;
                    w_load_head = 1'b1;
                end
            end
            BUF_ONE: begin
                if (w_accept && !w_pop) begin
                    w_state_nxt = BUF_TWO;
                    w_load_skid = 1'b1;
                end else if (w_accept) begin
                    w_load_head = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_pop) begin
                    w_state_nxt    = BUF_ONE;
                    w_skid_to_head = 1'b1;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
        // Flush wins over any concurrent accept or pop; payload is left untouched.
        if (flush) begin
            w_state_nxt    = BUF_EMPTY;
            w_load_head    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_head = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BUF_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != BUF_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head_code <= '0;
            r_head_ill  <= 1'b0;
            r_head_insn <= '0;
            r_head_pc   <= '0;
`ifdef FP_DECODE_EN
            r_head_fp   <= 1'b0;
`endif
        end else if (w_load_head) begin
            r_head_code <= w_code;
            r_head_ill  <= w_illegal;
            r_head_insn <= insn_in;
            r_head_pc   <= pc_in;
`ifdef FP_DECODE_EN
            r_head_fp   <= w_fp;
`endif
        end else if (w_skid_to_head) begin
            r_head_code <= r_skid_code;
            r_head_ill  <= r_skid_ill;
            r_head_insn <= r_skid_insn;
            r_head_pc   <= r_skid_pc;
`ifdef FP_DECODE_EN
            r_head_fp   <= r_skid_fp;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_code <= w_code;
            r_skid_ill  <= w_illegal;
            r_skid_insn <= insn_in;
            r_skid_pc   <= pc_in;
`ifdef FP_DECODE_EN
            r_skid_fp   <= w_fp;
`endif
        end
    end

    assign code     = r_head_code;
    assign illegal  = r_head_ill;
    assign insn_out = r_head_insn;
    assign pc_out   = r_head_pc;
`ifdef FP_DECODE_EN
    assign fp       = r_head_fp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_insn_class_decode.sv
//------------------------------------------------------------------------------
// Module  : tb_insn_class_decode
// Brief   : Directed scoreboard bench for insn_class_decode (RV64_W=1 main
//           instance plus an RV64_W=0 instance on the same stimulus).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_insn_class_decode;

    typedef struct {
        logic [9:0]  code;
        logic        ill;
        logic        fp;
        logic [31:0] insn;
        logic [63:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] insn_in;
    logic [63:0] pc_in;
    logic        out_ready;

    logic        in_ready,  in_ready0;
    logic        out_valid, out_valid0;
    logic [9:0]  code,      code0;
    logic [31:0] insn_out,  insn_out0;
    logic [63:0] pc_out,    pc_out0;
    logic        illegal,   illegal0;
`ifdef FP_DECODE_EN
    logic        fp, fp0;
`endif

    int n_checks = 0;
    int n_err    = 0;
    exp_t q[$];

    insn_class_decode #(.XLEN(64), .RV64_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .insn_in(insn_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .code(code), .insn_out(insn_out), .pc_out(pc_out), .illegal(illegal)
`ifdef FP_DECODE_EN
        , .fp(fp)
`endif
    );

    insn_class_decode #(.XLEN(64), .RV64_W(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .insn_in(insn_in), .pc_in(pc_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .code(code0), .insn_out(insn_out0), .pc_out(pc_out0), .illegal(illegal0)
`ifdef FP_DECODE_EN
        , .fp(fp0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference class table for the RV64_W=1 instance.
    function automatic exp_t ref_entry(input logic [31:0] insn, input logic [63:0] pc);
        exp_t e;
        e.code = 10'd0;
        e.fp   = 1'b0;
        e.insn = insn;
        e.pc   = pc;
        case (insn[6:0])
            7'h6F: e.code = 10'h001;
            7'h67: e.code = 10'h002;
            7'h37: e.code = 10'h004;
            7'h17: e.code = 10'h008;
            7'h63: e.code = 10'h010;
            7'h33, 7'h3B: e.code = 10'h020;
            7'h23: e.code = 10'h040;
            7'h13, 7'h1B: e.code = 10'h080;
            7'h03: e.code = 10'h100;
            7'h73: e.code = 10'h200;
`ifdef FP_DECODE_EN
            7'h07: begin e.code = 10'h100; e.fp = 1'b1; end
            7'h27: begin e.code = 10'h040; e.fp = 1'b1; end
            7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: begin e.code = 10'h020; e.fp = 1'b1; end
`endif
            default: e.code = 10'd0;
        endcase
        e.ill = (e.code == 10'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the scoreboard, then advance one clock and update it.
    task automatic tick();
        logic acc;
        logic pp;
        chk("in_ready",   {63'd0, in_ready},   {63'd0, q.size() != 2});
        chk("out_valid",  {63'd0, out_valid},  {63'd0, q.size() != 0});
        chk("in_ready0",  {63'd0, in_ready0},  {63'd0, q.size() != 2});
        chk("out_valid0", {63'd0, out_valid0}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("code",     {54'd0, code},     {54'd0, q[0].code});
            chk("illegal",  {63'd0, illegal},  {63'd0, q[0].ill});
            chk("insn_out", {32'd0, insn_out}, {32'd0, q[0].insn});
            chk("pc_out",   pc_out,            q[0].pc);
`ifdef FP_DECODE_EN
            chk("fp",       {63'd0, fp},       {63'd0, q[0].fp});
`endif
        end
        acc = in_valid && (q.size() < 2);
        pp  = out_ready && (q.size() > 0);
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(ref_entry(insn_in, pc_in));
        end
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
        chk({tag, "_code"},      {54'd0, code},      64'd0);
        chk({tag, "_illegal"},   {63'd0, illegal},   64'd0);
        chk({tag, "_insn_out"},  {32'd0, insn_out},  64'd0);
        chk({tag, "_pc_out"},    pc_out,             64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        insn_in   = 32'd0;
        pc_in     = 64'd0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Single JAL, one-cycle latency
        in_valid = 1'b1; insn_in = 32'h0000006F; pc_in = 64'h1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_code",      {54'd0, code},      64'h001);
        chk("t1_pc_out",    pc_out,             64'h1000);
        tick();

        // Back-to-back stream
        in_valid = 1'b1;
        insn_in = 32'h00100093; pc_in = 64'h1004; tick();
        insn_in = 32'h00100073; pc_in = 64'h1008; tick();
        insn_in = 32'h00002003; pc_in = 64'h100C; tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Backpressure fills the skid, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        insn_in = 32'h000002B7; pc_in = 64'h2000; tick();
        insn_in = 32'h00000297; pc_in = 64'h2004; tick();
        insn_in = 32'h00112023; pc_in = 64'h2008; tick();
        chk("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
        chk("t3_head_hold",     {32'd0, insn_out}, 64'h000002B7);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Illegal opcodes and the RV64_W split
        in_valid = 1'b1;
        insn_in = 32'hFFFFFFFF; pc_in = 64'h3000; tick();
        chk("t4_ffff_code0", {54'd0, code0},    64'd0);
        chk("t4_ffff_ill0",  {63'd0, illegal0}, 64'd1);
        insn_in = 32'h0000003B; pc_in = 64'h3004; tick();
        chk("t4_w_code0",    {54'd0, code0},     64'd0);
        chk("t4_w_ill0",     {63'd0, illegal0},  64'd1);
        chk("t4_w_insn0",    {32'd0, insn_out0}, 64'h0000003B);
        chk("t4_w_pc0",      pc_out0,            64'h3004);
        insn_in = 32'h00000070; pc_in = 64'h3008; tick();
        insn_in = 32'h0000001B; pc_in = 64'h300C; tick();
        chk("t4_opimmw_ill0", {63'd0, illegal0}, 64'd1);
        in_valid = 1'b0;
        tick();

        // Flush while full with a concurrent in_valid
        out_ready = 1'b0; in_valid = 1'b1;
        insn_in = 32'h00000063; pc_in = 64'h4000; tick();
        insn_in = 32'h00000067; pc_in = 64'h4004; tick();
        flush = 1'b1; insn_in = 32'h00000033; pc_in = 64'h4008; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_flush_in_ready",  {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        tick();
        tick();

        // Reset while full
        out_ready = 1'b0; in_valid = 1'b1;
        insn_in = 32'h00000013; pc_in = 64'h5000; tick();
        insn_in = 32'h00000023; pc_in = 64'h5004; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; in_valid = 1'b0;
        chk_zero_outputs("t5_reset");

        // OP-FP: fp class with FP_DECODE_EN, illegal otherwise
        out_ready = 1'b1; in_valid = 1'b1;
        insn_in = 32'h00007053; pc_in = 64'h6000; tick();
        in_valid = 1'b0;
`ifdef FP_DECODE_EN
        chk("t6_fp_code", {54'd0, code}, 64'h020);
        chk("t6_fp",      {63'd0, fp},   64'd1);
        chk("t6_fp0",     {63'd0, fp0},  64'd1);
`else
        chk("t6_fp_code",    {54'd0, code},    64'd0);
        chk("t6_fp_illegal", {63'd0, illegal}, 64'd1);
`endif
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
